mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, giving the multiply latency in cycles.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, giving the divide latency in cycles.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port RE_n SHALL be an input, 1 bit wide, and is the reset; reset is asynchronous and active-low.
REQ-005 Port Start SHALL be an input, 1 bit wide, and is a one-cycle request to begin the operation selected by MDOp.
REQ-006 Port MDOp SHALL be an input, 2 bits wide: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port A SHALL be an input, 32 bits wide, and is operand rs (multiplicand or dividend).
REQ-008 Port B SHALL be an input, 32 bits wide, and is operand rt (multiplier or divisor).
REQ-009 Port HIWrite SHALL be an input, 1 bit wide, and is the mthi strobe.
REQ-010 Port LOWrite SHALL be an input, 1 bit wide, and is the mtlo strobe.
REQ-011 Port WD SHALL be an input, 32 bits wide, and is the data for mthi/mtlo.
REQ-012 Port MDSel SHALL be an input, 1 bit wide: 0 selects LO and 1 selects HI onto MDOut (mflo/mfhi).
REQ-013 Port Busy SHALL be an output, 1 bit wide, and is high while an operation is in flight; the hazard unit stalls on it.
REQ-014 Ports HI and LO SHALL be outputs, 32 bits wide each, and are the architectural HI and LO registers.
REQ-015 Port MDOut SHALL be an output, 32 bits wide, and is the selected HI or LO value; it feeds the register-file write-data mux.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE, Start=1 at edge k SHALL latch A, B, MDOp, load the counter with MULT_CYC or DIV_CYC, and enter RUN.
REQ-018 Busy SHALL be 1 during the cycles after edges k through k+N-1, where N is the latency; Busy SHALL be 0 after edge k+N.
REQ-019 At edge k+N, HI/LO SHALL take the result and the FSM SHALL return to IDLE; the new values are visible on the cycle after that edge.
REQ-020 MULT SHALL compute the signed 64-bit product and MULTU the unsigned 64-bit product; HI={P[63:32]} and LO={P[31:0]}.
REQ-021 DIV/DIVU SHALL put the quotient in LO and the remainder in HI; the signed quotient truncates toward zero and the signed remainder takes the sign of the dividend.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 Divide with B=0 SHALL still occupy DIV_CYC cycles and leave HI/LO unchanged.
REQ-024 Results SHALL use only the latched operands; changes on A, B, MDOp during RUN SHALL have no effect.
REQ-025 Start while in RUN SHALL be ignored: no restart, no queueing.
REQ-026 HIWrite/LOWrite in IDLE SHALL write WD into HI/LO at the edge; both strobes together SHALL write both registers.
REQ-027 HIWrite/LOWrite while in RUN SHALL be ignored.
REQ-028 If Start and HIWrite/LOWrite are asserted in the same IDLE cycle, Start SHALL take priority and the write is dropped.
REQ-029 MDOut SHALL be combinational from the current HI/LO and MDSel, with no added latency; during RUN it shows the pre-operation values.
REQ-030 The counter SHALL be at least 5 bits wide.
REQ-031 Any parameter value below 1 SHALL be treated as 1.

Reset
REQ-032 RE_n=0 SHALL immediately, without waiting for clk, force IDLE, Busy=0, HI=0, LO=0, and counter=0.
REQ-033 Reset mid-operation SHALL abort the operation, and no result SHALL be written afterward.
REQ-034 The first edge with RE_n=1 SHALL accept Start or writes normally.

Verification
REQ-035 MULT with A=0xFFFFFFFE, B=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-036 DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-037 With HI=0x11, LO=0x22, DIVU with B=0 -> Busy for 10 cycles, then HI=0x11 and LO=0x22 are unchanged.
REQ-038 Start a MULT, then at cycle 2 pulse Start (DIV), pulse HIWrite with WD=0xDEAD, and change A -> only the original MULT result lands, at cycle 5, and HI≠0xDEAD.
REQ-039 Start a DIV, then drop RE_n at cycle 4 (between edges) -> Busy, HI, and LO go to 0 at once; after release, no write occurs at cycle 10.
REQ-040 In IDLE, assert Start and LOWrite together with WD=0x55 -> LO=0x55 is never seen and the operation result is written.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Each operation runs a fixed latency; results come only from operands latched at start.
module mult_div_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        RE_n,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic [31:0] WD,
    input  logic        MDSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MULT_N = (MULT_CYC < 1) ? 1 : MULT_CYC;
    localparam int DIV_N  = (DIV_CYC < 1) ? 1 : DIV_CYC;
    localparam int MAX_N  = (MULT_N > DIV_N) ? MULT_N : DIV_N;
    localparam int CNT_W  = ($clog2(MAX_N + 1) < 5) ? 5 : $clog2(MAX_N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             op_q;
    logic [31:0]            a_q;
    logic [31:0]            b_q;
    logic [63:0]            res;
    logic                   res_ok;

    // Zero- or sign-extend to 64 bits; the low 64 bits of the product are exact either way.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}; the most-negative / -1 overflow case is pinned explicitly.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (!is_signed) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        if (!op_q[1]) begin
            res = mul64(a_q, b_q, !op_q[0]);
        end else begin
            res_ok = (b_q != 32'd0);
            res    = div64(a_q, b_q, !op_q[0]);
        end
    end

    // Operand capture: datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && Start) begin
            op_q <= MDOp;
            a_q  <= A;
            b_q  <= B;
        end
    end

    always_ff @(posedge clk or negedge RE_n) begin
        if (!RE_n) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                        cnt   <= MDOp[1] ? CNT_W'(DIV_N) : CNT_W'(MULT_N);
                    end else begin
                        if (HIWrite) HI <= WD;
                        if (LOWrite) LO <= WD;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        if (res_ok) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign MDOut = MDSel ? HI : LO;

endmodule
